// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width: clog2(WIDTH), never less than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider_div_trial_sub.sv
// WIDTH+1 bit trial subtractor (a + ~b + 1); the MSB of the result is the borrow.
module div_trial_sub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH:0]   i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    logic [WIDTH:0] w_sum;

    assign w_sum    = i_a + ~i_b + {{WIDTH{1'b0}}, 1'b1};
    assign o_diff   = w_sum[WIDTH-1:0];
    assign o_borrow = w_sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional SEQ_DIVIDER_SIGNED_EN adds signed_op for two's complement operands.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;

    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_q_iter;
    logic [WIDTH-1:0]   w_r_iter;
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};

    div_trial_sub #(
        .WIDTH (WIDTH)
    ) u_trial (
        .i_a      (w_rem_sh),
        .i_b      ({1'b0, r_dvs}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_q_iter = {r_dvd[WIDTH-2:0], ~w_borrow};
    assign w_r_iter = w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg_q;
    logic r_neg_r;

    // Divide magnitudes; the most-negative value maps onto itself and reads as 2^(WIDTH-1).
    assign w_a_neg   = signed_op & A[WIDTH-1];
    assign w_b_neg   = signed_op & B[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -A : A;
    assign w_b_mag   = w_b_neg ? -B : B;
    assign w_q_final = r_neg_q ? -w_q_iter : w_q_iter;
    assign w_r_final = r_neg_r ? -w_r_iter : w_r_iter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (start && r_state != RUN) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    assign w_a_mag   = A;
    assign w_b_mag   = B;
    assign w_q_final = w_q_iter;
    assign w_r_final = w_r_iter;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            Q           <= '0;
            R           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_rem       <= '0;
                        r_cnt       <= '0;
                        r_dvd       <= w_a_mag;
                        r_dvs       <= w_b_mag;
                        div_by_zero <= 1'b0;
                        if (B == '0) begin
                            // Zero divisor skips the iterations entirely.
                            r_state     <= DONE;
                            Q           <= '1;
                            R           <= A;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            busy    <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem <= w_r_iter;
                    r_dvd <= w_q_iter;
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        Q       <= w_q_final;
                        R       <= w_r_final;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
